// File: rtl/prb_pkg.sv
// rtl/prb_pkg.sv - shared types and bit helpers for the early-termination controller
// Helpers work on up to 32-bit words; callers pass the live width and slice the result.
package prb_pkg;

   localparam int PRB_MAXW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RUN  = 2'd2
   } prb_state_e;

   // Reverse the low w bits of v; bits at or above w come back as zero.
   function automatic logic [PRB_MAXW-1:0] bitrev(input logic [PRB_MAXW-1:0] v, input int w);
      logic [PRB_MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < PRB_MAXW; i++) begin
         if (i < w) r[5'(w - 1 - i)] = v[i];
      end
      return r;
   endfunction

   // Trailing zeros within the low w bits; an all-zero word yields w.
   function automatic int tzc(input logic [PRB_MAXW-1:0] v, input int w);
      int n;
      n = w;
      for (int i = PRB_MAXW - 1; i >= 0; i--) begin
         if (i < w && v[i]) n = i;
      end
      return n;
   endfunction

endpackage

// File: rtl/prb_tzc.sv
// rtl/prb_tzc.sv - combinational trailing-zero counter, W for an all-zero word
module prb_tzc
   import prb_pkg::*;
#(
   parameter int W  = 8,
   parameter int ZW = $clog2(W + 1)
) (
   input  logic [W-1:0]  x_i,
   output logic [ZW-1:0] cnt_o
);

   assign cnt_o = ZW'(tzc(PRB_MAXW'(x_i), W));

endmodule

// File: rtl/prb_et_ctrl.sv
// rtl/prb_et_ctrl.sv - early-termination controller: finds the exact stream length per job
// and streams bit-reversed comparison values with per-channel completion flags.
module prb_et_ctrl
   import prb_pkg::*;
#(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int CORR = 0,
   parameter int ZW   = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  Bxs [N-1:0],
   input  logic          et_en,
   output logic [W-1:0]  rn,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [N-1:0]  ch_active,
   output logic [ZW-1:0] z_min
);

   localparam logic [W-1:0] ONES = '1;

   prb_state_e     state_q;
   logic           in_ready_q;
   logic           et_q;
   logic [W-1:0]   bxs_q [N-1:0];
   logic [ZW-1:0]  t_q   [N-1:0];
   logic [W-1:0]   k_q;
   logic [W-1:0]   rn_q;
   logic [ZW-1:0]  z_min_q;
   logic           out_valid_q;
   logic           out_last_q;
   logic [N-1:0]   ch_active_q;

   logic [W-1:0]   or_w;
   logic [ZW-1:0]  z_raw;
   logic [ZW-1:0]  z_eff;
   logic [ZW-1:0]  t_raw [N-1:0];
   logic [ZW-1:0]  t_eff [N-1:0];
   logic [W-1:0]   k_nx;
   logic [N-1:0]   ch_nx;

   always_comb begin
      or_w = '0;
      for (int j = 0; j < N; j++) or_w = or_w | bxs_q[j];
   end

   prb_tzc #(.W(W), .ZW(ZW)) u_tzc_or (.x_i(or_w), .cnt_o(z_raw));

   // The shared-length build never looks at individual operand lengths.
   if (CORR == 0) begin : g_ch
      for (genvar j = 0; j < N; j++) begin : g_tzc
         prb_tzc #(.W(W), .ZW(ZW)) u_tzc (.x_i(bxs_q[j]), .cnt_o(t_raw[j]));
      end
   end else begin : g_corr
      for (genvar j = 0; j < N; j++) begin : g_zero
         assign t_raw[j] = '0;
      end
   end

   assign z_eff = et_q ? z_raw : '0;
   assign k_nx  = k_q + W'(1);

   always_comb begin
      for (int j = 0; j < N; j++) begin
         t_eff[j] = (CORR != 0 || !et_q) ? z_eff : t_raw[j];
         ch_nx[j] = (k_nx <= (ONES >> t_q[j]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         et_q        <= 1'b0;
         k_q         <= '0;
         rn_q        <= '0;
         z_min_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         ch_active_q <= '0;
         for (int j = 0; j < N; j++) begin
            bxs_q[j] <= '0;
            t_q[j]   <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  bxs_q      <= Bxs;
                  et_q       <= et_en;
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               z_min_q     <= z_eff;
               t_q         <= t_eff;
               k_q         <= '0;
               rn_q        <= '0;
               out_valid_q <= 1'b1;
               out_last_q  <= (z_eff == ZW'(W));
               ch_active_q <= '1;
               state_q     <= RUN;
            end
            RUN: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     rn_q        <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     ch_active_q <= '0;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end else begin
                     k_q         <= k_nx;
                     rn_q        <= W'(bitrev(PRB_MAXW'(k_nx), W));
                     out_last_q  <= (k_nx == (ONES >> z_min_q));
                     ch_active_q <= ch_nx;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign rn        = rn_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign ch_active = ch_active_q;
   assign z_min     = z_min_q;

endmodule

// File: tb/tb_prb_et_ctrl.sv
// tb/tb_prb_et_ctrl.sv - self-checking bench: per-channel and shared-length builds in lockstep
module tb_prb_et_ctrl;

   localparam int W  = 4;
   localparam int N  = 2;
   localparam int ZW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  bxs [N-1:0];
   logic          et_en;
   logic          out_ready;
   logic          in_ready0, in_ready1;
   logic [W-1:0]  rn0, rn1;
   logic          out_valid0, out_valid1;
   logic          out_last0, out_last1;
   logic [N-1:0]  ch0, ch1;
   logic [ZW-1:0] z_min0, z_min1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prb_et_ctrl #(.W(W), .N(N), .CORR(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .Bxs(bxs),
      .et_en(et_en), .rn(rn0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_last(out_last0), .ch_active(ch0), .z_min(z_min0));

   prb_et_ctrl #(.W(W), .N(N), .CORR(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .Bxs(bxs),
      .et_en(et_en), .rn(rn1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_last(out_last1), .ch_active(ch1), .z_min(z_min1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting on the DUT", nm);
   endtask

   // Largest s <= W such that b is divisible by 2^s.
   function automatic int tz_m(input int b);
      int s;
      s = 0;
      while (s < W && (b % (1 << (s + 1))) == 0) s++;
      return s;
   endfunction

   function automatic int rev_m(input int i);
      int r;
      r = 0;
      for (int b = 0; b < W; b++) r = r * 2 + ((i >> b) & 1);
      return r;
   endfunction

   function automatic int min_z(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic et);
      int a, b;
      a = tz_m(int'(b0));
      b = tz_m(int'(b1));
      return et ? ((a < b) ? a : b) : 0;
   endfunction

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (!in_ready0 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!in_ready0) timeout("wait_idle");
   endtask

   // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready plus ignored operands.
   task automatic run_job(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic et,
                          input int mode, input int ez);
      int len, idx, cyc, t0, t1;
      logic rdy, held;
      logic [W-1:0] h_rn;
      logic h_last;
      logic [N-1:0] h_ch0, h_ch1, e_ch0;
      len = 1 << (W - ez);
      t0  = et ? tz_m(int'(b0)) : 0;
      t1  = et ? tz_m(int'(b1)) : 0;
      wait_idle();
      bxs[0] = b0; bxs[1] = b1; et_en = et; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bxs[0] = W'($urandom); bxs[1] = W'($urandom); et_en = 1'($urandom);
      chk("calc_in_ready", 32'(in_ready0), 0);
      chk("calc_out_valid", 32'(out_valid0), 0);
      @(posedge clk); #1;
      chk("first_out_valid", 32'(out_valid0), 1);
      chk("z_min", 32'(z_min0), 32'(ez));
      chk("z_min_corr", 32'(z_min1), 32'(ez));
      idx = 0; held = 1'b0; cyc = 0;
      h_rn = '0; h_last = 1'b0; h_ch0 = '0; h_ch1 = '0;
      while (idx < len && cyc < 400) begin
         if (held) begin
            chk("hold_valid", 32'(out_valid0), 1);
            chk("hold_rn", 32'(rn0), 32'(h_rn));
            chk("hold_last", 32'(out_last0), 32'(h_last));
            chk("hold_ch", 32'(ch0), 32'(h_ch0));
            chk("hold_ch_corr", 32'(ch1), 32'(h_ch1));
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
         out_ready = rdy;
         in_valid = (mode == 2);
         if (out_valid0 && rdy) begin
            e_ch0[0] = (idx < (1 << (W - t0)));
            e_ch0[1] = (idx < (1 << (W - t1)));
            chk("rn", 32'(rn0), 32'(rev_m(idx)));
            chk("rn_corr", 32'(rn1), 32'(rev_m(idx)));
            chk("out_last", 32'(out_last0), 32'(idx == len - 1));
            chk("out_last_corr", 32'(out_last1), 32'(idx == len - 1));
            chk("ch_active", 32'(ch0), 32'(e_ch0));
            chk("ch_active_corr", 32'(ch1), 32'({N{1'b1}}));
            idx++;
            held = 1'b0;
         end else begin
            held = out_valid0;
            h_rn = rn0; h_last = out_last0; h_ch0 = ch0; h_ch1 = ch1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      if (idx < len) timeout("job_outputs");
      chk("done_out_valid", 32'(out_valid0), 0);
      chk("done_out_valid_corr", 32'(out_valid1), 0);
      chk("done_in_ready", 32'(in_ready0), 1);
   endtask

   typedef struct {
      logic [W-1:0] b0;
      logic [W-1:0] b1;
      logic         et;
      int           mode;
      int           ez;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [W-1:0] r0, r1;
      logic         ret;

      vecs[0] = '{b0: 4'b1000, b1: 4'b0100, et: 1'b1, mode: 0, ez: 2};
      vecs[1] = '{b0: 4'b1000, b1: 4'b0100, et: 1'b0, mode: 0, ez: 0};
      vecs[2] = '{b0: 4'b0000, b1: 4'b0000, et: 1'b1, mode: 0, ez: 4};
      vecs[3] = '{b0: 4'b0110, b1: 4'b0011, et: 1'b1, mode: 1, ez: 0};
      vecs[4] = '{b0: 4'b1000, b1: 4'b0010, et: 1'b1, mode: 0, ez: 1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; et_en = 1'b0;
      bxs[0] = '0; bxs[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready0), 1);
      chk("rst_out_valid", 32'(out_valid0), 0);
      chk("rst_rn", 32'(rn0), 0);
      chk("rst_z_min", 32'(z_min0), 0);
      chk("rst_ch_active", 32'(ch0), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++)
         run_job(vecs[v].b0, vecs[v].b1, vecs[v].et, vecs[v].mode, vecs[v].ez);

      // Reset mid-RUN with k=3 on the outputs, then a fresh job restarts at rn=0.
      wait_idle();
      bxs[0] = 4'b1000; bxs[1] = 4'b0100; et_en = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_rn", 32'(rn0), 32'(rev_m(3)));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid0), 0);
      chk("mid_rst_rn", 32'(rn0), 0);
      chk("mid_rst_out_last", 32'(out_last0), 0);
      chk("mid_rst_ch_active", 32'(ch0), 0);
      chk("mid_rst_z_min", 32'(z_min0), 0);
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready0), 1);
      run_job(4'b1000, 4'b0100, 1'b1, 0, 2);

      for (int i = 0; i < 25; i++) begin
         r0  = W'(($urandom % 16) << ($urandom % 4));
         r1  = W'(($urandom % 16) << ($urandom % 4));
         ret = 1'($urandom);
         run_job(r0, r1, ret, 2, min_z(r0, r1, ret));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
